player_health: RTL and testbench

- Sequential producer of the 10-bit Player_Blood value consumed by the HUD blood-bar renderer.
- Tracks player health from damage and heal events, frame-paced regeneration, a post-hit invulnerability window, god-mode capacity switching and death.
- Sits between the game-logic/collision blocks and the HUD and game-over logic.
- Runs on the system clock; all frame-paced behaviour is derived from frame_clk edges.

---
 rtl/player_health_pkg.sv | 19 +
 rtl/frame_edge_det.sv | 22 ++
 rtl/player_health.sv | 128 ++++++++++++
 tb/tb_player_health.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_health_pkg.sv
// Shared health types and blood capacities for the player health block and the HUD.
// The clamp helper keeps blood within the current capacity after an addition.
package player_health_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } health_state_t;

  localparam int FULL_NOGOD = 50;
  localparam int FULL_GOD   = 300;

  function automatic logic [9:0] clamp_blood(input logic [10:0] value,
                                             input logic [9:0]  limit);
    return (value > {1'b0, limit}) ? limit : value[9:0];
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Turns the vsync frame clock into a one-cycle frame_tick pulse in the system clock domain.
// The tick is registered, so it appears the cycle after frame_clk is first sampled high.
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_prev <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_prev <= frame_clk;
      frame_tick <= frame_clk & ~frame_prev;
    end
  end

endmodule

// File: rtl/player_health.sv
// Player blood tracker: damage, healing, frame-paced regeneration, hit immunity,
// god-mode capacity switching and death. Exactly one blood update is applied per cycle.
module player_health
  import player_health_pkg::*;
#(
  parameter int FULL_NOGOD    = player_health_pkg::FULL_NOGOD,
  parameter int FULL_GOD      = player_health_pkg::FULL_GOD,
  parameter int REGEN_FRAMES  = 60,
  parameter int INVULN_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       Restart,
  input  logic       Godmode_On,
  input  logic       Hit,
  input  logic [7:0] Hit_Damage,
  input  logic       Heal,
  input  logic [7:0] Heal_Amount,
  output logic [9:0] Player_Blood,
  output logic       Player_Dead,
  output logic       Invuln
);

  localparam int RW = $clog2(REGEN_FRAMES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);
  localparam logic [9:0] MAX_NOGOD = 10'(FULL_NOGOD);
  localparam logic [9:0] MAX_GOD   = 10'(FULL_GOD);

  logic          frame_tick;
  health_state_t state, state_next;
  logic [9:0]    blood, blood_next, cur_max;
  logic [RW-1:0] regen_cnt, regen_cnt_next;
  logic [IW-1:0] inv_cnt, inv_cnt_next;
  logic          god_prev, god_rise, god_fall, hit_ok, regen_wrap;
  logic [10:0]   heal_sum, regen_sum;

  frame_edge_det u_frame_edge (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  // Timers advance independently of which blood update wins; the priority chain
  // below then picks the single blood/state update for this cycle.
  always_comb begin
    cur_max        = Godmode_On ? MAX_GOD : MAX_NOGOD;
    god_rise       = Godmode_On & ~god_prev;
    god_fall       = ~Godmode_On & god_prev;
    hit_ok         = Hit && (state == ALIVE) && !Restart && !god_rise && !god_fall;
    heal_sum       = {1'b0, blood} + {3'b000, Heal_Amount};
    regen_sum      = {1'b0, blood} + 11'd1;
    state_next     = state;
    blood_next     = blood;
    inv_cnt_next   = inv_cnt;
    regen_cnt_next = regen_cnt;
    regen_wrap     = 1'b0;

    if (state == INVULN && frame_tick) begin
      if (inv_cnt == IW'(INVULN_FRAMES - 1)) begin
        state_next   = ALIVE;
        inv_cnt_next = '0;
      end else begin
        inv_cnt_next = inv_cnt + 1'b1;
      end
    end

    if (state != DEAD && frame_tick) begin
      if (regen_cnt == RW'(REGEN_FRAMES - 1)) begin
        regen_cnt_next = '0;
        regen_wrap     = 1'b1;
      end else begin
        regen_cnt_next = regen_cnt + 1'b1;
      end
    end

    if (Restart) begin
      blood_next     = cur_max;
      state_next     = ALIVE;
      inv_cnt_next   = '0;
      regen_cnt_next = '0;
    end else if (god_rise) begin
      blood_next = MAX_GOD;
      if (state == DEAD) state_next = ALIVE;
    end else if (god_fall) begin
      blood_next = (blood > MAX_NOGOD) ? MAX_NOGOD : blood;
    end else if (hit_ok) begin
      regen_cnt_next = '0;
      inv_cnt_next   = '0;
      if ({2'b00, Hit_Damage} < blood) begin
        blood_next = blood - {2'b00, Hit_Damage};
        state_next = INVULN;
      end else if (Godmode_On) begin
        blood_next = 10'd1;
        state_next = INVULN;
      end else begin
        blood_next = 10'd0;
        state_next = DEAD;
      end
    end else if (Heal && state != DEAD) begin
      blood_next = clamp_blood(heal_sum, cur_max);
    end else if (regen_wrap) begin
      blood_next = clamp_blood(regen_sum, cur_max);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ALIVE;
      blood     <= MAX_NOGOD;
      regen_cnt <= '0;
      inv_cnt   <= '0;
      god_prev  <= 1'b0;
    end else begin
      state     <= state_next;
      blood     <= blood_next;
      regen_cnt <= regen_cnt_next;
      inv_cnt   <= inv_cnt_next;
      god_prev  <= Godmode_On;
    end
  end

  assign Player_Blood = blood;
  assign Player_Dead  = (state == DEAD);
  assign Invuln       = (state == INVULN);

endmodule

// File: tb/tb_player_health.sv
// Self-checking bench for player_health: directed scenarios plus randomized traffic
// compared against an integer reference model of the health rules.
module tb_player_health;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       Restart = 1'b0;
  logic       Godmode_On = 1'b0;
  logic       Hit = 1'b0;
  logic [7:0] Hit_Damage = 8'd0;
  logic       Heal = 1'b0;
  logic [7:0] Heal_Amount = 8'd0;
  logic [9:0] Player_Blood;
  logic       Player_Dead;
  logic       Invuln;

  int checks = 0;
  int failures = 0;

  int m_blood, m_rc, m_ic;
  bit m_dead, m_inv, m_fprev, m_tick, m_gprev;

  player_health dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .Restart     (Restart),
    .Godmode_On  (Godmode_On),
    .Hit         (Hit),
    .Hit_Damage  (Hit_Damage),
    .Heal        (Heal),
    .Heal_Amount (Heal_Amount),
    .Player_Blood(Player_Blood),
    .Player_Dead (Player_Dead),
    .Invuln      (Invuln)
  );

  always #5 Clk = ~Clk;

  // Reference model: plain integer bookkeeping of blood, life/immunity flags and frame counts.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_blood = 50; m_dead = 0; m_inv = 0; m_rc = 0; m_ic = 0;
      m_fprev = 0; m_tick = 0; m_gprev = 0;
    end else begin
      automatic int cap = Godmode_On ? 300 : 50;
      automatic bit rise = Godmode_On && !m_gprev;
      automatic bit fall = !Godmode_On && m_gprev;
      automatic bit was_dead = m_dead;
      automatic bit was_inv = m_inv;
      automatic bit wrap = 0;
      if (was_inv && m_tick) begin
        m_ic++;
        if (m_ic == 30) begin m_inv = 0; m_ic = 0; end
      end
      if (!was_dead && m_tick) begin
        m_rc++;
        if (m_rc == 60) begin m_rc = 0; wrap = 1; end
      end
      if (Restart) begin
        m_blood = cap; m_dead = 0; m_inv = 0; m_rc = 0; m_ic = 0;
      end else if (rise) begin
        m_blood = 300; m_dead = 0;
      end else if (fall) begin
        if (m_blood > 50) m_blood = 50;
      end else if (Hit && !was_dead && !was_inv) begin
        m_rc = 0; m_ic = 0;
        if (int'(Hit_Damage) < m_blood) begin m_blood -= int'(Hit_Damage); m_inv = 1; end
        else if (Godmode_On) begin m_blood = 1; m_inv = 1; end
        else begin m_blood = 0; m_dead = 1; end
      end else if (Heal && !was_dead) begin
        m_blood = (m_blood + int'(Heal_Amount) > cap) ? cap : m_blood + int'(Heal_Amount);
      end else if (wrap) begin
        m_blood = (m_blood + 1 > cap) ? cap : m_blood + 1;
      end
      m_tick  = frame_clk && !m_fprev;
      m_fprev = frame_clk;
      m_gprev = Godmode_On;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_clk = 1'b1; cycles(2);
      frame_clk = 1'b0; cycles(2);
    end
  endtask

  task automatic pulse_hit(input int dmg);
    Hit = 1'b1; Hit_Damage = 8'(dmg); cycles(1); Hit = 1'b0;
  endtask

  task automatic pulse_heal(input int amt);
    Heal = 1'b1; Heal_Amount = 8'(amt); cycles(1); Heal = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; cycles(1); Reset = 1'b0; cycles(1);
  endtask

  task automatic test_reset();
    #1 Reset = 1'b1;
    cycles(2);
    checks++;
    if ({Player_Blood, Player_Dead, Invuln} !== {10'd50, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got blood=%0d dead=%0b inv=%0b, expected 50/0/0", Player_Blood, Player_Dead, Invuln);
    end
    Reset = 1'b0;
    cycles(3);
    checks++;
    if ({Player_Blood, Player_Dead, Invuln} !== {10'(m_blood), m_dead, m_inv}) begin
      failures++;
      $display("[TB] FAIL reset_idle: got blood=%0d dead=%0b inv=%0b, expected %0d/%0b/%0b", Player_Blood, Player_Dead, Invuln, m_blood, m_dead, m_inv);
    end
  endtask

  task automatic test_reset_mid();
    pulse_hit(30);
    checks++;
    if ({Player_Blood, Invuln} !== {10'd20, 1'b1}) begin
      failures++;
      $display("[TB] FAIL mid_setup: got blood=%0d inv=%0b, expected 20/1", Player_Blood, Invuln);
    end
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Player_Blood, Player_Dead, Invuln} !== {10'd50, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL async_reset: got blood=%0d dead=%0b inv=%0b, expected 50/0/0", Player_Blood, Player_Dead, Invuln);
    end
    @(negedge Clk);
    Reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_invuln();
    pulse_hit(10);
    checks++;
    if ({Player_Blood, Invuln} !== {10'd40, 1'b1}) begin
      failures++;
      $display("[TB] FAIL invuln_first_hit: got blood=%0d inv=%0b, expected 40/1", Player_Blood, Invuln);
    end
    frames(5);
    pulse_hit(10);
    checks++;
    if ({Player_Blood, Invuln} !== {10'd40, 1'b1}) begin
      failures++;
      $display("[TB] FAIL invuln_ignore_hit: got blood=%0d inv=%0b, expected 40/1", Player_Blood, Invuln);
    end
    frames(24);
    checks++;
    if (Invuln !== 1'b1) begin
      failures++;
      $display("[TB] FAIL invuln_29_ticks: got inv=%0b, expected 1", Invuln);
    end
    frames(1);
    checks++;
    if ({Player_Blood, Invuln} !== {10'd40, 1'b0}) begin
      failures++;
      $display("[TB] FAIL invuln_30_ticks: got blood=%0d inv=%0b, expected 40/0", Player_Blood, Invuln);
    end
  endtask

  task automatic test_death();
    do_reset();
    pulse_hit(60);
    checks++;
    if ({Player_Blood, Player_Dead, Invuln} !== {10'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL death: got blood=%0d dead=%0b inv=%0b, expected 0/1/0", Player_Blood, Player_Dead, Invuln);
    end
    pulse_heal(20);
    frames(2);
    checks++;
    if ({Player_Blood, Player_Dead} !== {10'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL dead_heal_ignored: got blood=%0d dead=%0b, expected 0/1", Player_Blood, Player_Dead);
    end
    Restart = 1'b1; cycles(1); Restart = 1'b0;
    checks++;
    if ({Player_Blood, Player_Dead, Invuln} !== {10'd50, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL restart: got blood=%0d dead=%0b inv=%0b, expected 50/0/0", Player_Blood, Player_Dead, Invuln);
    end
  endtask

  task automatic test_godmode();
    Godmode_On = 1'b1; cycles(1);
    checks++;
    if (Player_Blood !== 10'd300) begin
      failures++;
      $display("[TB] FAIL god_rise: got blood=%0d, expected 300", Player_Blood);
    end
    pulse_hit(255);
    frames(30);
    pulse_hit(255);
    checks++;
    if ({Player_Blood, Player_Dead} !== {10'd1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL god_floor: got blood=%0d dead=%0b, expected 1/0", Player_Blood, Player_Dead);
    end
    Godmode_On = 1'b0; cycles(1);
    checks++;
    if (Player_Blood !== 10'd1) begin
      failures++;
      $display("[TB] FAIL god_fall_low: got blood=%0d, expected 1", Player_Blood);
    end
    Godmode_On = 1'b1; cycles(1);
    frames(30);
    pulse_hit(50);
    checks++;
    if (Player_Blood !== 10'd250) begin
      failures++;
      $display("[TB] FAIL god_hit_250: got blood=%0d, expected 250", Player_Blood);
    end
    Godmode_On = 1'b0; cycles(1);
    checks++;
    if (Player_Blood !== 10'd50) begin
      failures++;
      $display("[TB] FAIL god_fall_clamp: got blood=%0d, expected 50", Player_Blood);
    end
    frames(30);
  endtask

  task automatic test_regen();
    do_reset();
    pulse_hit(5);
    frames(59);
    checks++;
    if (Player_Blood !== 10'd45) begin
      failures++;
      $display("[TB] FAIL regen_59: got blood=%0d, expected 45", Player_Blood);
    end
    frames(1);
    checks++;
    if (Player_Blood !== 10'd46) begin
      failures++;
      $display("[TB] FAIL regen_60: got blood=%0d, expected 46", Player_Blood);
    end
    for (int i = 0; i < 360; i++) begin
      frames(1);
      if (Player_Blood > 10'd50) begin
        checks++; failures++;
        $display("[TB] FAIL regen_cap: got blood=%0d, expected <= 50", Player_Blood);
      end
    end
    checks++;
    if (Player_Blood !== 10'd50) begin
      failures++;
      $display("[TB] FAIL regen_full: got blood=%0d, expected 50", Player_Blood);
    end
    Hit = 1'b1; Hit_Damage = 8'd3; Heal = 1'b1; Heal_Amount = 8'd20;
    cycles(1);
    Hit = 1'b0; Heal = 1'b0;
    checks++;
    if ({Player_Blood, Invuln} !== {10'd47, 1'b1}) begin
      failures++;
      $display("[TB] FAIL hit_over_heal: got blood=%0d inv=%0b, expected 47/1", Player_Blood, Invuln);
    end
  endtask

  task automatic test_heal_clamp();
    do_reset();
    pulse_hit(5);
    pulse_heal(200);
    checks++;
    if (Player_Blood !== 10'd50) begin
      failures++;
      $display("[TB] FAIL heal_clamp_normal: got blood=%0d, expected 50", Player_Blood);
    end
    Godmode_On = 1'b1; cycles(1);
    frames(30);
    pulse_hit(10);
    pulse_heal(255);
    checks++;
    if (Player_Blood !== 10'd300) begin
      failures++;
      $display("[TB] FAIL heal_clamp_god: got blood=%0d, expected 300", Player_Blood);
    end
    Godmode_On = 1'b0; cycles(1);
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      frame_clk   = 1'($urandom_range(0, 1));
      Restart     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 149) == 0) Godmode_On = ~Godmode_On;
      Hit         = ($urandom_range(0, 5) == 0);
      Hit_Damage  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
      Heal        = ($urandom_range(0, 5) == 0);
      Heal_Amount = 8'($urandom_range(0, 255));
      cycles(1);
      checks++;
      if ({Player_Blood, Player_Dead, Invuln} !== {10'(m_blood), m_dead, m_inv}) begin
        failures++;
        if (shown < 10) begin
          shown++;
          $display("[TB] FAIL random_cycle_%0d: got blood=%0d dead=%0b inv=%0b, expected %0d/%0b/%0b", i, Player_Blood, Player_Dead, Invuln, m_blood, m_dead, m_inv);
        end
      end
    end
    Restart = 1'b0; Hit = 1'b0; Heal = 1'b0; frame_clk = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_invuln();
    test_death();
    test_godmode();
    test_regen();
    test_heal_clamp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
